instr_prefetch_buffer: RTL and testbench
========================================

// Module: instr_prefetch_buffer
// PURPOSE
//  Fetch stage feeding the single-cycle CPU decode path: replaces the direct PC->Instruction_Memory
//  lookup with a latency-tolerant fetcher. Issues word fetches over a req/ack memory port, buffers
//  up to DEPTH {pc,instr} pairs in a FIFO, presents them to the CPU with valid/ready, and flushes
//  on a redirect (taken branch, j/jal, jr) driven from the CPU's next-PC logic.
// PARAMETERS
//  DEPTH     4    FIFO entries; power of two, >=2
//  RESET_PC  0    first fetch address after reset (word aligned)
// PORTS
//  clk_i          in   1   clock; all state updates on rising edge
//  rst_i          in   1   synchronous reset, active-high
//  redirect_i     in   1   flush buffer and restart fetch at redirect_pc_i
//  redirect_pc_i  in   32  new fetch address; bits [1:0] forced to 0
//  mem_req_o      out  1   fetch request, held until acked
//  mem_addr_o     out  32  fetch address, stable while mem_req_o=1
//  mem_ack_i      in   1   memory done; mem_data_i valid this cycle (may be same cycle as req)
//  mem_data_i     in   32  fetched instruction word
//  instr_valid_o  out  1   FIFO head valid
//  instr_o        out  32  FIFO head instruction; 0 when empty
//  instr_pc_o     out  32  address of instr_o; 0 when empty
//  instr_ready_i  in   1   CPU consumes head when instr_valid_o=1
// BEHAVIOUR
//  Reset (rst_i=1 at edge): state=IDLE, count=0, rd/wr ptrs=0, fetch_pc=RESET_PC, mem_req_o=0,
//   mem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0. Reset overrides all inputs.
//  FSM (mem_req_o = state!=IDLE, registered; mem_addr_o = fetch_pc register):
//   IDLE: count_next<DEPTH -> REQ, else stay.
//   REQ : ack & ~redirect -> push {fetch_pc,mem_data_i}; fetch_pc+=4; REQ if count_next<DEPTH else IDLE.
//         ~ack & redirect -> DROP (outstanding request may not be withdrawn).
//         ack & redirect  -> word discarded; IDLE.
//   DROP: keeps mem_req_o=1 with old address; ack -> data discarded, IDLE. Redirect in DROP stays
//         DROP with updated fetch_pc.
//  mem_addr_o changes only in cycles after an ack edge or when entering IDLE; never while req pending un-acked.
//  Exactly one outstanding fetch; ack while mem_req_o=0 is ignored.
//  Redirect (any state): count=0, ptrs=0, fetch_pc=redirect_pc_i&~3 at edge; a same-cycle pop or
//   push is cancelled; instr_valid_o=0 next cycle.
//  Pop: instr_valid_o & instr_ready_i & ~redirect_i advances rd ptr.
//  count_next = count + push - pop; requests are only launched with count_next<DEPTH, so push
//   never overflows; simultaneous push+pop when count=DEPTH-1 keeps count, stays in REQ.
//  fetch_pc wraps 0xFFFF_FFFC -> 0x0000_0000. Pointers wrap mod DEPTH.
//  Latency: reset release -> mem_req_o=1 next cycle; ack at edge N -> instr_valid_o=1 after edge N.
//  Throughput: 1 instr/cycle with same-cycle ack and CPU ready every cycle.
//  instr_valid_o = (count!=0); head outputs taken from FIFO storage, zeroed when empty.
// TESTING
//  1 Reset, same-cycle ack, ready=1 -> mem_addr_o 0,4,8,C on consecutive cycles; instr_pc_o
//    trails by one cycle with matching mem_data_i; no bubbles.
//  2 ready=0, DEPTH=4 -> exactly 4 acks accepted, then mem_req_o=0, count=4; one ready pulse
//    -> pop PC 0x0, new request at 0x10 next cycle.
//  3 ack delayed 3 cycles -> mem_req_o held and mem_addr_o stable for all 3 cycles; one push.
//  4 redirect_i=1 to 0x0000_0103 while request to 0x8 pending un-acked -> DROP; ack data
//    discarded; next request addr 0x0000_0100; FIFO empty in between.
//  5 redirect and ack same cycle, FIFO holding 2 entries -> valid=0 next cycle, acked word never
//    appears, fetch restarts at redirect target.
//  6 RESET_PC=0xFFFF_FFF8, ready=1 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000; rst_i mid-fetch
//    -> all outputs to reset values next cycle, in-flight ack ignored.

Source files
------------

// File: rtl/instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : instr_prefetch_buffer
// Brief    : Latency-tolerant instruction fetcher with a small {pc,instr} FIFO,
//            one outstanding req/ack fetch and redirect-driven flush.
// Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i
);

    localparam int unsigned c_ptr_w = $clog2(DEPTH);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_drop = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        w_fetch_pc_next;
    logic [31:0]        r_mem_addr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_count_next;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic               w_push;
    logic               w_pop;
    logic               w_valid;

    logic [31:0]        r_buf_pc    [DEPTH];
    logic [31:0]        r_buf_instr [DEPTH];

    always_comb begin
        w_valid         = (r_count != '0);
        w_push          = (r_state == c_st_req) && mem_ack_i && !redirect_i;
        w_pop           = w_valid && instr_ready_i && !redirect_i;
        w_fetch_pc_next = r_fetch_pc;
        w_state_next    = r_state;

        if (redirect_i) begin
            w_count_next    = '0;
            w_fetch_pc_next = redirect_pc_i & ~32'h0000_0003;
        end else begin
            w_count_next = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            if (w_push) begin
                w_fetch_pc_next = r_fetch_pc + 32'd4;
            end
        end

        // A request, once issued, must complete; redirect while un-acked parks in DROP.
        case (r_state)
            c_st_idle: begin
                if (w_count_next < c_depth) begin
                    w_state_next = c_st_req;
                end
            end
            c_st_req: begin
                if (mem_ack_i) begin
                    if (redirect_i || (w_count_next >= c_depth)) begin
                        w_state_next = c_st_idle;
                    end
                end else if (redirect_i) begin
                    w_state_next = c_st_drop;
                end
            end
            c_st_drop: begin
                if (mem_ack_i) begin
                    w_state_next = c_st_idle;
                end
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= c_st_idle;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_fetch_pc <= w_fetch_pc_next;
            // Bus address stays on the old word until the dropped fetch completes.
            if (w_state_next != c_st_drop) begin
                r_mem_addr <= w_fetch_pc_next;
            end
            if (redirect_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_buf_pc[r_wr_ptr]    <= r_fetch_pc;
            r_buf_instr[r_wr_ptr] <= mem_data_i;
        end
    end

    assign mem_req_o     = (r_state != c_st_idle);
    assign mem_addr_o    = r_mem_addr;
    assign instr_valid_o = w_valid;
    assign instr_o       = w_valid ? r_buf_instr[r_rd_ptr] : 32'h0;
    assign instr_pc_o    = w_valid ? r_buf_pc[r_rd_ptr]    : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_prefetch_buffer
// Brief    : Self-checking bench for instr_prefetch_buffer with a pop scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch_buffer;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    logic        rst_w;
    logic        redirect_w;
    logic [31:0] redirect_pc_w;
    logic        mem_req_w;
    logic [31:0] mem_addr_w;
    logic        mem_ack_w;
    logic [31:0] mem_data_w;
    logic        instr_valid_w;
    logic [31:0] instr_w;
    logic [31:0] instr_pc_w;
    logic        instr_ready_w;

    int          n_cmp;
    int          n_bad;
    logic [63:0] sb [$];
    logic [31:0] m_pc;

    instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk_i(clk), .rst_i(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_data_i(mem_data),
        .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
        .instr_ready_i(instr_ready)
    );

    instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk_i(clk), .rst_i(rst_w), .redirect_i(redirect_w), .redirect_pc_i(redirect_pc_w),
        .mem_req_o(mem_req_w), .mem_addr_o(mem_addr_w), .mem_ack_i(mem_ack_w),
        .mem_data_i(mem_data_w), .instr_valid_o(instr_valid_w), .instr_o(instr_w),
        .instr_pc_o(instr_pc_w), .instr_ready_i(instr_ready_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, a[31:16] ^ 16'h3C5A};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every accepted CPU pop is checked against the oldest expected {pc,instr}.
    always @(negedge clk) begin
        if (!rst && instr_valid && instr_ready && !redirect) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_pop: got pc=%h instr=%h, expected no entry", instr_pc, instr);
            end else begin
                logic [63:0] exp;
                exp = sb.pop_front();
                if ({instr_pc, instr} !== exp) begin
                    n_bad++;
                    $display("FAIL sb_pop: got pc=%h instr=%h, expected pc=%h instr=%h",
                             instr_pc, instr, exp[63:32], exp[31:0]);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_ack = 1'b0;
        mem_data = '0; instr_ready = 1'b0;
        tick(); tick();
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", mem_req); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", mem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", instr_pc); end
        rst = 1'b0;
        tick();
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL reset_release_req: got %b want 1", mem_req); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_release_addr: got %h want 0", mem_addr); end
    endtask

    task automatic test_stream();
        instr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            a = 32'(4 * i);
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr !== a) begin
                n_bad++; $display("FAIL stream_addr: got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, a);
            end
            n_cmp++;
            if (instr_valid !== (i > 0)) begin
                n_bad++; $display("FAIL stream_valid: got %b want %b at beat %0d", instr_valid, (i > 0), i);
            end
            mem_ack = 1'b1; mem_data = data_of(a);
            sb.push_back({a, data_of(a)});
            tick();
        end
        mem_ack = 1'b0; mem_data = '0;
        tick();
        instr_ready = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drain: got valid=%b want 0", instr_valid); end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL stream_left: got %0d pending want 0", sb.size()); end
    endtask

    task automatic test_fill();
        int n;
        rst = 1'b1; mem_ack = 1'b0; instr_ready = 1'b0;
        tick();
        rst = 1'b0; sb.delete();
        tick();
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'(4 * i);
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr !== a) begin
                n_bad++; $display("FAIL fill_addr: got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, a);
            end
            mem_ack = 1'b1; mem_data = data_of(a);
            sb.push_back({a, data_of(a)});
            tick();
        end
        mem_ack = 1'b0;
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL fill_full_req: got %b want 0", mem_req); end
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            n_bad++; $display("FAIL fill_head: got valid=%b pc=%h want valid=1 pc=0", instr_valid, instr_pc);
        end
        mem_ack = 1'b1; mem_data = 32'hBAD0_0001;
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL fill_ack_ignored: got req=%b want 0", mem_req); end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
            n_bad++; $display("FAIL fill_refetch: got req=%b addr=%h want req=1 addr=00000010", mem_req, mem_addr);
        end
        n_cmp++; if (instr_pc !== 32'h4) begin n_bad++; $display("FAIL fill_next_head: got %h want 00000004", instr_pc); end
        mem_ack = 1'b1; mem_data = data_of(32'h10);
        sb.push_back({32'h10, data_of(32'h10)});
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (mem_req !== 1'b0) begin n_bad++; $display("FAIL fill_refull: got req=%b want 0", mem_req); end
        instr_ready = 1'b1;
        n = 0;
        while (instr_valid && n < 10) begin
            tick();
            n++;
        end
        instr_ready = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL fill_drain_timeout: got valid=%b want 0", instr_valid); end
        n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL fill_left: got %0d pending want 0", sb.size()); end
        m_pc = 32'h14;
    endtask

    task automatic test_slow_ack();
        mem_ack = 1'b0; instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr !== m_pc) begin
                n_bad++; $display("FAIL slow_hold: got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, m_pc);
            end
            tick();
        end
        mem_ack = 1'b1; mem_data = data_of(m_pc);
        sb.push_back({m_pc, data_of(m_pc)});
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== m_pc) begin
            n_bad++; $display("FAIL slow_push: got valid=%b pc=%h want valid=1 pc=%h", instr_valid, instr_pc, m_pc);
        end
        n_cmp++; if (mem_addr !== m_pc + 32'd4) begin
            n_bad++; $display("FAIL slow_next_addr: got %h want %h", mem_addr, m_pc + 32'd4);
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || sb.size() != 0) begin
            n_bad++; $display("FAIL slow_single: got valid=%b pending=%0d want 0/0", instr_valid, sb.size());
        end
    endtask

    task automatic test_redirect_drop();
        rst = 1'b1; mem_ack = 1'b0; instr_ready = 1'b0;
        tick();
        rst = 1'b0; sb.delete();
        tick();
        for (int i = 0; i < 2; i++) begin
            mem_ack = 1'b1; mem_data = data_of(32'(4 * i));
            tick();
        end
        mem_ack = 1'b0;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            n_bad++; $display("FAIL drop_pre: got req=%b addr=%h want req=1 addr=00000008", mem_req, mem_addr);
        end
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL drop_flush: got valid=%b want 0", instr_valid); end
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            n_bad++; $display("FAIL drop_hold: got req=%b addr=%h want req=1 addr=00000008", mem_req, mem_addr);
        end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
            n_bad++; $display("FAIL drop_hold2: got req=%b addr=%h want req=1 addr=00000008", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_data = 32'hDEAD_0008;
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (mem_req !== 1'b0 || mem_addr !== 32'h100 || instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL drop_done: got req=%b addr=%h valid=%b want 0/00000100/0", mem_req, mem_addr, instr_valid);
        end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL drop_restart: got req=%b addr=%h valid=%b want 1/00000100/0", mem_req, mem_addr, instr_valid);
        end
    endtask

    task automatic test_redirect_ack();
        instr_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] a;
            a = 32'h100 + 32'(4 * i);
            n_cmp++;
            if (mem_req !== 1'b1 || mem_addr !== a) begin
                n_bad++; $display("FAIL redir_ack_addr: got req=%b addr=%h want req=1 addr=%h", mem_req, mem_addr, a);
            end
            mem_ack = 1'b1; mem_data = data_of(a);
            sb.push_back({a, data_of(a)});
            tick();
        end
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100) begin
            n_bad++; $display("FAIL redir_ack_pre: got valid=%b pc=%h want 1/00000100", instr_valid, instr_pc);
        end
        redirect = 1'b1; redirect_pc = 32'h0000_2000;
        mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF; instr_ready = 1'b1;
        sb.delete();
        tick();
        redirect = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'h2000) begin
            n_bad++; $display("FAIL redir_ack_flush: got valid=%b req=%b addr=%h want 0/0/00002000", instr_valid, mem_req, mem_addr);
        end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h2000 || instr_valid !== 1'b0) begin
            n_bad++; $display("FAIL redir_ack_restart: got req=%b addr=%h valid=%b want 1/00002000/0", mem_req, mem_addr, instr_valid);
        end
        mem_ack = 1'b1; mem_data = data_of(32'h2000);
        sb.push_back({32'h2000, data_of(32'h2000)});
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 32'h2000 || instr !== data_of(32'h2000)) begin
            n_bad++; $display("FAIL redir_ack_first: got valid=%b pc=%h instr=%h want 1/00002000/%h", instr_valid, instr_pc, instr, data_of(32'h2000));
        end
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || sb.size() != 0) begin
            n_bad++; $display("FAIL redir_ack_left: got valid=%b pending=%0d want 0/0", instr_valid, sb.size());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        logic [31:0] prev;
        rst_w = 1'b1; mem_ack_w = 1'b0; instr_ready_w = 1'b0;
        tick();
        n_cmp++; if (mem_req_w !== 1'b0 || mem_addr_w !== 32'hFFFF_FFF8) begin
            n_bad++; $display("FAIL wrap_reset: got req=%b addr=%h want 0/FFFFFFF8", mem_req_w, mem_addr_w);
        end
        rst_w = 1'b0;
        tick();
        instr_ready_w = 1'b1;
        a = 32'hFFFF_FFF8;
        prev = '0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (mem_req_w !== 1'b1 || mem_addr_w !== a) begin
                n_bad++; $display("FAIL wrap_addr: got req=%b addr=%h want req=1 addr=%h", mem_req_w, mem_addr_w, a);
            end
            if (i > 0) begin
                n_cmp++;
                if (instr_valid_w !== 1'b1 || instr_pc_w !== prev || instr_w !== data_of(prev)) begin
                    n_bad++; $display("FAIL wrap_head: got valid=%b pc=%h instr=%h want 1/%h/%h",
                                      instr_valid_w, instr_pc_w, instr_w, prev, data_of(prev));
                end
            end
            mem_ack_w = 1'b1; mem_data_w = data_of(a);
            tick();
            prev = a;
            a = a + 32'd4;
        end
        n_cmp++; if (mem_addr_w !== 32'h4 || instr_pc_w !== 32'h0) begin
            n_bad++; $display("FAIL wrap_zero: got addr=%h pc=%h want 00000004/00000000", mem_addr_w, instr_pc_w);
        end
        rst_w = 1'b1; mem_ack_w = 1'b1; mem_data_w = 32'h1234_5678;
        tick();
        rst_w = 1'b0; mem_ack_w = 1'b0; instr_ready_w = 1'b0;
        n_cmp++; if (mem_req_w !== 1'b0 || mem_addr_w !== 32'hFFFF_FFF8 || instr_valid_w !== 1'b0 ||
                     instr_w !== 32'h0 || instr_pc_w !== 32'h0) begin
            n_bad++; $display("FAIL wrap_midreset: got req=%b addr=%h valid=%b instr=%h pc=%h want 0/FFFFFFF8/0/0/0",
                              mem_req_w, mem_addr_w, instr_valid_w, instr_w, instr_pc_w);
        end
        tick();
        n_cmp++; if (mem_req_w !== 1'b1 || mem_addr_w !== 32'hFFFF_FFF8 || instr_valid_w !== 1'b0) begin
            n_bad++; $display("FAIL wrap_restart: got req=%b addr=%h valid=%b want 1/FFFFFFF8/0",
                              mem_req_w, mem_addr_w, instr_valid_w);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0; n_bad = 0; m_pc = '0;
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; mem_ack = 1'b0; mem_data = '0; instr_ready = 1'b0;
        rst_w = 1'b1; redirect_w = 1'b0; redirect_pc_w = '0; mem_ack_w = 1'b0; mem_data_w = '0; instr_ready_w = 1'b0;
        test_reset();
        test_stream();
        test_fill();
        test_slow_ack();
        test_redirect_drop();
        test_redirect_ack();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
